// File: rtl/dag_addr_gen_if.sv
// Sequencer <-> data address generator bus: decode strobes, ureg traffic, returned addresses.
// master = program sequencer side, slave = address generator side.
interface dag_addr_gen_if #(
    parameter int AW = 16
);
    logic          ps_dg_en;
    logic          ps_dg_dgsclt;
    logic          ps_dg_mdfy;
    logic [2:0]    ps_dg_iadd;
    logic [2:0]    ps_dg_madd;
    logic          ps_dg_wrt_en;
    logic [4:0]    ps_dg_wrt_add;
    logic [4:0]    ps_dg_rd_add;
    logic [AW-1:0] bc_dt;
    logic [AW-1:0] dg_bc_dt;
    logic [AW-1:0] dg_ps_add;
    logic [AW-1:0] dg_dm_add;
    logic          dg_dm_vld;

    modport master (
        output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
        output ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
        input  dg_bc_dt, dg_ps_add, dg_dm_add, dg_dm_vld
    );

    modport slave (
        input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
        input  ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
        output dg_bc_dt, dg_ps_add, dg_dm_add, dg_dm_vld
    );
endinterface

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M register file with pre/post-modify addressing, PM target and DM address.
// Optional circular buffering (L/B registers) is enabled by defining DAG_CIRC_BUF_EN.
module dag_addr_gen #(
    parameter int AW   = 16,
    parameter int NREG = 8
) (
    input  logic           clk,
    input  logic           rst,
    dag_addr_gen_if.slave  bus
);

`ifdef DAG_CIRC_BUF_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    logic [AW-1:0] i_reg [NREG];
    logic [AW-1:0] m_reg [NREG];

    logic [1:0]    wr_bank;
    logic [2:0]    wr_idx;
    logic          wr_impl;
    logic [1:0]    rd_bank;
    logic [2:0]    rd_idx;

    logic [AW-1:0]        i_eff;
    logic signed [AW-1:0] m_eff;
    logic signed [AW-1:0] sum_p0;
    logic [AW-1:0]        addr_p0;
    logic [AW-1:0]        i_next_p0;
    logic                 post_upd_p0;
    logic                 dm_req_p0;
    logic                 wr_hits_i;

    logic [AW-1:0] dm_add_p1;
    logic          vld_p1;
    logic [AW-1:0] rd_data;

    assign wr_bank = bus.ps_dg_wrt_add[4:3];
    assign wr_idx  = bus.ps_dg_wrt_add[2:0];
    assign rd_bank = bus.ps_dg_rd_add[4:3];
    assign rd_idx  = bus.ps_dg_rd_add[2:0];
    assign wr_impl = bus.ps_dg_wrt_en && (!wr_bank[1] || CIRC);

    // Effective I/M: a same-cycle ureg write is forwarded so the address uses the new value.
    assign i_eff = (bus.ps_dg_wrt_en && wr_bank == 2'b00 && wr_idx == bus.ps_dg_iadd)
                   ? bus.bc_dt : i_reg[bus.ps_dg_iadd];
    assign m_eff = (bus.ps_dg_wrt_en && wr_bank == 2'b01 && wr_idx == bus.ps_dg_madd)
                   ? $signed(bus.bc_dt) : $signed(m_reg[bus.ps_dg_madd]);

    assign sum_p0  = $signed(i_eff) + m_eff;
    assign addr_p0 = bus.ps_dg_mdfy ? $unsigned(sum_p0) : i_eff;

    assign post_upd_p0 = bus.ps_dg_en && !bus.ps_dg_mdfy;
    assign dm_req_p0   = bus.ps_dg_en && !bus.ps_dg_dgsclt;
    assign wr_hits_i   = bus.ps_dg_wrt_en && wr_bank == 2'b00;

    assign bus.dg_ps_add = (bus.ps_dg_en && bus.ps_dg_dgsclt) ? addr_p0 : '0;

`ifdef DAG_CIRC_BUF_EN
    logic [AW-1:0] l_reg [NREG];
    logic [AW-1:0] b_reg [NREG];
    logic [AW-1:0] l_eff;
    logic [AW-1:0] b_eff;

    assign l_eff = (bus.ps_dg_wrt_en && wr_bank == 2'b10 && wr_idx == bus.ps_dg_iadd)
                   ? bus.bc_dt : l_reg[bus.ps_dg_iadd];
    assign b_eff = (bus.ps_dg_wrt_en && wr_bank == 2'b11 && wr_idx == bus.ps_dg_iadd)
                   ? bus.bc_dt : b_reg[bus.ps_dg_iadd];

    // Window limit is computed one bit wider so B+L near the top of memory does not alias.
    function automatic logic [AW-1:0] circ_wrap(input logic [AW-1:0] n,
                                                input logic [AW-1:0] base,
                                                input logic [AW-1:0] len);
        logic [AW:0] lim;
        lim = {1'b0, base} + {1'b0, len};
        if (len == '0)
            circ_wrap = n;
        else if ({1'b0, n} >= lim)
            circ_wrap = n - len;
        else if (n < base)
            circ_wrap = n + len;
        else
            circ_wrap = n;
    endfunction

    assign i_next_p0 = circ_wrap($unsigned(sum_p0), b_eff, l_eff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) begin
                l_reg[k] <= '0;
                b_reg[k] <= '0;
            end
        end else if (bus.ps_dg_wrt_en) begin
            if (wr_bank == 2'b10) l_reg[wr_idx] <= bus.bc_dt;
            if (wr_bank == 2'b11) b_reg[wr_idx] <= bus.bc_dt;
        end
    end
`else
    assign i_next_p0 = $unsigned(sum_p0);
`endif

    // Register file update: ureg write to an I register beats a post-modify of the same I.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREG; k++) begin
                i_reg[k] <= '0;
                m_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (wr_hits_i && wr_idx == 3'(k))
                    i_reg[k] <= bus.bc_dt;
                else if (post_upd_p0 && bus.ps_dg_iadd == 3'(k))
                    i_reg[k] <= i_next_p0;
            end
            if (bus.ps_dg_wrt_en && wr_bank == 2'b01)
                m_reg[wr_idx] <= bus.bc_dt;
        end
    end

    // Stage p0 -> p1: registered DM address and valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_add_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= dm_req_p0;
            if (dm_req_p0)
                dm_add_p1 <= addr_p0;
        end
    end

    assign bus.dg_dm_add = dm_add_p1;
    assign bus.dg_dm_vld = vld_p1;

    always_comb begin
        rd_data = '0;
        case (rd_bank)
            2'b00:   rd_data = i_reg[rd_idx];
            2'b01:   rd_data = m_reg[rd_idx];
`ifdef DAG_CIRC_BUF_EN
            2'b10:   rd_data = l_reg[rd_idx];
            2'b11:   rd_data = b_reg[rd_idx];
`endif
            default: rd_data = '0;
        endcase
        if (wr_impl && bus.ps_dg_rd_add == bus.ps_dg_wrt_add)
            rd_data = bus.bc_dt;
    end

    assign bus.dg_bc_dt = rd_data;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Directed self-checking bench for dag_addr_gen (linear mode; circular checks when DAG_CIRC_BUF_EN is defined).
module tb_dag_addr_gen;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dag_addr_gen_if #(.AW(16)) bus ();

    dag_addr_gen #(.AW(16), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.ps_dg_en      = 1'b0;
        bus.ps_dg_dgsclt  = 1'b0;
        bus.ps_dg_mdfy    = 1'b0;
        bus.ps_dg_iadd    = 3'd0;
        bus.ps_dg_madd    = 3'd0;
        bus.ps_dg_wrt_en  = 1'b0;
        bus.ps_dg_wrt_add = 5'd0;
        bus.ps_dg_rd_add  = 5'd0;
        bus.bc_dt         = 16'h0;
    endtask

    task automatic ureg_write(input logic [4:0] a, input logic [15:0] d);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = a;
        bus.bc_dt         = d;
        @(posedge clk); #1;
        bus.ps_dg_wrt_en  = 1'b0;
    endtask

    task automatic ureg_read(input logic [4:0] a, output logic [15:0] d);
        bus.ps_dg_rd_add = a;
        #1;
        d = bus.dg_bc_dt;
    endtask

    task automatic request(input logic sclt, input logic mdfy, input logic [2:0] i, input logic [2:0] m);
        bus.ps_dg_en     = 1'b1;
        bus.ps_dg_dgsclt = sclt;
        bus.ps_dg_mdfy   = mdfy;
        bus.ps_dg_iadd   = i;
        bus.ps_dg_madd   = m;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dg_dm_vld !== 1'b0) begin
            failures++; $display("FAIL reset_vld got=%0b want=0", bus.dg_dm_vld);
        end
        checks++;
        if (bus.dg_dm_add !== 16'h0) begin
            failures++; $display("FAIL reset_dm_add got=%h want=0000", bus.dg_dm_add);
        end
        checks++;
        if (bus.dg_ps_add !== 16'h0) begin
            failures++; $display("FAIL reset_ps_add got=%h want=0000", bus.dg_ps_add);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            ureg_read(5'(a), rd);
            checks++;
            if (rd !== 16'h0) begin
                failures++; $display("FAIL reset_reg[%0d] got=%h want=0000", a, rd);
            end
        end
    endtask

    task automatic test_dm_postmod();
        logic [15:0] rd;
        logic [15:0] exp_add;
        ureg_write(5'b00010, 16'h0100);
        ureg_write(5'b01011, 16'h0004);
        exp_add = 16'h0100;
        for (int n = 0; n < 3; n++) begin
            request(1'b0, 1'b0, 3'd2, 3'd3);
            #1;
            checks++;
            if (bus.dg_ps_add !== 16'h0) begin
                failures++; $display("FAIL dm_ps_add_zero got=%h want=0000", bus.dg_ps_add);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.dg_dm_add !== exp_add || bus.dg_dm_vld !== 1'b1) begin
                failures++;
                $display("FAIL dm_post[%0d] got=%h/%0b want=%h/1", n, bus.dg_dm_add, bus.dg_dm_vld, exp_add);
            end
            exp_add = exp_add + 16'h0004;
        end
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (bus.dg_dm_vld !== 1'b0 || bus.dg_dm_add !== 16'h0108) begin
            failures++; $display("FAIL dm_hold got=%h/%0b want=0108/0", bus.dg_dm_add, bus.dg_dm_vld);
        end
        ureg_read(5'b00010, rd);
        checks++;
        if (rd !== 16'h010C) begin
            failures++; $display("FAIL dm_i2_final got=%h want=010c", rd);
        end
    endtask

    task automatic test_pm_modify();
        logic [15:0] rd;
        ureg_write(5'b00001, 16'h0020);
        ureg_write(5'b01001, 16'h0010);
        request(1'b1, 1'b1, 3'd1, 3'd1);
        #1;
        checks++;
        if (bus.dg_ps_add !== 16'h0030) begin
            failures++; $display("FAIL pm_pre_add got=%h want=0030", bus.dg_ps_add);
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (bus.dg_dm_vld !== 1'b0) begin
            failures++; $display("FAIL pm_no_dm_vld got=%0b want=0", bus.dg_dm_vld);
        end
        ureg_read(5'b00001, rd);
        checks++;
        if (rd !== 16'h0020) begin
            failures++; $display("FAIL pm_pre_i1 got=%h want=0020", rd);
        end
        // PM post-modify: target is I, I advances by M
        request(1'b1, 1'b0, 3'd1, 3'd1);
        #1;
        checks++;
        if (bus.dg_ps_add !== 16'h0020) begin
            failures++; $display("FAIL pm_post_add got=%h want=0020", bus.dg_ps_add);
        end
        @(posedge clk); #1;
        idle_inputs();
        ureg_read(5'b00001, rd);
        checks++;
        if (rd !== 16'h0030) begin
            failures++; $display("FAIL pm_post_i1 got=%h want=0030", rd);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rd;
        ureg_write(5'b01000, 16'hFFFF);
        ureg_write(5'b00000, 16'h0000);
        request(1'b0, 1'b0, 3'd0, 3'd0);
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (bus.dg_dm_add !== 16'h0000 || bus.dg_dm_vld !== 1'b1) begin
            failures++; $display("FAIL wrap_add got=%h/%0b want=0000/1", bus.dg_dm_add, bus.dg_dm_vld);
        end
        ureg_read(5'b00000, rd);
        checks++;
        if (rd !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_i0 got=%h want=ffff", rd);
        end
    endtask

    task automatic test_write_wins();
        logic [15:0] rd;
        ureg_write(5'b01010, 16'h0002);
        ureg_write(5'b00100, 16'h0111);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = 5'b00100;
        bus.bc_dt         = 16'h0555;
        bus.ps_dg_rd_add  = 5'b00100;
        request(1'b0, 1'b0, 3'd4, 3'd2);
        #1;
        checks++;
        if (bus.dg_bc_dt !== 16'h0555) begin
            failures++; $display("FAIL bypass_rd got=%h want=0555", bus.dg_bc_dt);
        end
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (bus.dg_dm_add !== 16'h0555) begin
            failures++; $display("FAIL bypass_add got=%h want=0555", bus.dg_dm_add);
        end
        ureg_read(5'b00100, rd);
        checks++;
        if (rd !== 16'h0555) begin
            failures++; $display("FAIL write_wins_i4 got=%h want=0555", rd);
        end
    endtask

    task automatic test_idle_no_change();
        logic [15:0] rd;
        bus.ps_dg_en     = 1'b0;
        bus.ps_dg_mdfy   = 1'b0;
        bus.ps_dg_iadd   = 3'd2;
        bus.ps_dg_madd   = 3'd3;
        #1;
        checks++;
        if (bus.dg_ps_add !== 16'h0) begin
            failures++; $display("FAIL idle_ps_add got=%h want=0000", bus.dg_ps_add);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.dg_dm_vld !== 1'b0) begin
            failures++; $display("FAIL idle_vld got=%0b want=0", bus.dg_dm_vld);
        end
        ureg_read(5'b00010, rd);
        checks++;
        if (rd !== 16'h010C) begin
            failures++; $display("FAIL idle_i2 got=%h want=010c", rd);
        end
        idle_inputs();
    endtask

    task automatic test_circ();
        logic [15:0] rd;
`ifdef DAG_CIRC_BUF_EN
        ureg_write(5'b11101, 16'h0200);
        ureg_write(5'b10101, 16'h0008);
        ureg_write(5'b00101, 16'h0206);
        ureg_write(5'b01100, 16'h0003);
        request(1'b0, 1'b0, 3'd5, 3'd4);
        @(posedge clk); #1;
        idle_inputs();
        checks++;
        if (bus.dg_dm_add !== 16'h0206) begin
            failures++; $display("FAIL circ_add got=%h want=0206", bus.dg_dm_add);
        end
        ureg_read(5'b00101, rd);
        checks++;
        if (rd !== 16'h0201) begin
            failures++; $display("FAIL circ_i5 got=%h want=0201", rd);
        end
        ureg_write(5'b10101, 16'h0000);
        ureg_write(5'b00101, 16'h0206);
        request(1'b0, 1'b0, 3'd5, 3'd4);
        @(posedge clk); #1;
        idle_inputs();
        ureg_read(5'b00101, rd);
        checks++;
        if (rd !== 16'h0209) begin
            failures++; $display("FAIL linear_i5 got=%h want=0209", rd);
        end
`else
        ureg_write(5'b10011, 16'h1234);
        ureg_read(5'b10011, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++; $display("FAIL unimpl_l3 got=%h want=0000", rd);
        end
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = 5'b11001;
        bus.bc_dt         = 16'hABCD;
        bus.ps_dg_rd_add  = 5'b11001;
        #1;
        checks++;
        if (bus.dg_bc_dt !== 16'h0000) begin
            failures++; $display("FAIL unimpl_bypass got=%h want=0000", bus.dg_bc_dt);
        end
        idle_inputs();
`endif
    endtask

    task automatic test_reset_midop();
        logic [15:0] rd;
        request(1'b0, 1'b0, 3'd2, 3'd3);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dg_dm_vld !== 1'b0 || bus.dg_dm_add !== 16'h0) begin
            failures++; $display("FAIL midrst_dm got=%h/%0b want=0000/0", bus.dg_dm_add, bus.dg_dm_vld);
        end
        @(posedge clk); #1;
        ureg_read(5'b00010, rd);
        checks++;
        if (rd !== 16'h0000) begin
            failures++; $display("FAIL midrst_i2 got=%h want=0000", rd);
        end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_dm_postmod();
        test_pm_modify();
        test_wrap();
        test_write_wins();
        test_idle_no_change();
        test_circ();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
